// File: rtl/esr_clock_axi_v2_if.sv
// AXI4-Lite slave bundle for the ESR clock block, plus channel-state
// observation signals driven by the slave.
interface esr_clock_axi_v2_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    // Handshakes: a beat transfers on a rising edge where valid and ready are
    // both 1; a source holds valid and its payload stable until that edge.
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic                    wr_state_dbg;
    logic                    rd_state_dbg;

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        output wr_state_dbg, rd_state_dbg
    );

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        input  wr_state_dbg, rd_state_dbg
    );
endinterface

// File: rtl/esr_clock_axi_v2.sv
// Real-time clock (hh:mm:ss) with a seconds prescaler, controlled and
// observed through an AXI4-Lite register slave.
module esr_clock_axi_v2 #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_REGS         = 8,
    parameter int C_TICK_DIV         = 100000000
) (
    input  logic              ACLK,
    input  logic              ARESET,
    esr_clock_axi_v2_if.slave s_axi,
    output logic [5:0]        sec_o,
    output logic [5:0]        min_o,
    output logic [4:0]        hour_o,
    output logic              tick_o
);
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int STRB_W   = DW / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(C_NUM_REGS);
    localparam int PRESC_W  = $clog2(C_TICK_DIV);

    localparam logic [AW:0]          REG_SPAN   = (AW+1)'(C_NUM_REGS * STRB_W);
    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(C_TICK_DIV - 1);
    localparam logic [IDX_W-1:0]     IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0]     IDX_SET    = IDX_W'(1);
    localparam logic [IDX_W-1:0]     IDX_TIME   = IDX_W'(2);
    localparam logic [IDX_W-1:0]     IDX_STATUS = IDX_W'(3);
    localparam logic [1:0]           RESP_OKAY   = 2'b00;
    localparam logic [1:0]           RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_e;
    typedef enum logic {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_e;

    wr_state_e              wr_state_q, wr_state_d;
    rd_state_e              rd_state_q, rd_state_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [DW-1:0]          rdata_q, rdata_d;

    logic                   run_q, run_d;
    logic                   load_pend_q, load_pend_d;
    logic [5:0]             set_sec_q, set_sec_d;
    logic [5:0]             set_min_q, set_min_d;
    logic [4:0]             set_hour_q, set_hour_d;
    logic [5:0]             sec_q, sec_d;
    logic [5:0]             min_q, min_d;
    logic [4:0]             hour_q, hour_d;
    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic                   day_wrap_q, day_wrap_d;
    logic                   load_err_q, load_err_d;
    logic [DW-1:0]          scratch_q [C_NUM_REGS];
    logic [DW-1:0]          scratch_d [C_NUM_REGS];

    logic                   aw_hs;
    logic                   ar_hs;
    logic                   wr_oor;
    logic                   rd_oor;
    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic                   set_valid;
    logic [20:0]            set_word;
    logic [20:0]            time_word;
    logic [DW-1:0]          rd_word;
    logic                   unused_ok;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0]     old_v,
                                                  input logic [DW-1:0]     new_v,
                                                  input logic [STRB_W-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    assign wr_oor    = ({1'b0, s_axi.awaddr} >= REG_SPAN);
    assign rd_oor    = ({1'b0, s_axi.araddr} >= REG_SPAN);
    assign wr_idx    = s_axi.awaddr[ADDR_LSB +: IDX_W];
    assign rd_idx    = s_axi.araddr[ADDR_LSB +: IDX_W];
    assign wr_en     = aw_hs && !wr_oor;
    assign set_valid = (set_sec_q <= 6'd59) && (set_min_q <= 6'd59) && (set_hour_q <= 5'd23);
    assign set_word  = {set_hour_q, 2'b00, set_min_q, 2'b00, set_sec_q};
    assign time_word = {hour_q, 2'b00, min_q, 2'b00, sec_q};

    // Protection bits and sub-word address bits carry no meaning here.
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

    always_comb begin
        wr_state_d = wr_state_q;
        bresp_d    = bresp_q;
        aw_hs      = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (s_axi.awvalid && s_axi.wvalid && !ARESET) begin
                    aw_hs      = 1'b1;
                    wr_state_d = WR_RESP;
                    bresp_d    = wr_oor ? RESP_SLVERR : RESP_OKAY;
                end
            end
            WR_RESP: begin
                if (s_axi.bready) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            IDX_CTRL:   rd_word[0]    = run_q;
            IDX_SET:    rd_word[20:0] = set_word;
            IDX_TIME:   rd_word[20:0] = time_word;
            IDX_STATUS: rd_word[2:0]  = {load_err_q, day_wrap_q, run_q};
            default:    rd_word       = scratch_q[rd_idx];
        endcase
    end

    // Read data is captured at the address handshake, so a TIME read is a
    // snapshot that later ticks cannot disturb while RVALID waits.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        ar_hs      = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (s_axi.arvalid && !ARESET) begin
                    ar_hs      = 1'b1;
                    rd_state_d = RD_DATA;
                    rdata_d    = rd_oor ? '0 : rd_word;
                    rresp_d    = rd_oor ? RESP_SLVERR : RESP_OKAY;
                end
            end
            RD_DATA: begin
                if (s_axi.rready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        run_d       = run_q;
        load_pend_d = 1'b0;
        set_sec_d   = set_sec_q;
        set_min_d   = set_min_q;
        set_hour_d  = set_hour_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        presc_d     = presc_q;
        day_wrap_d  = day_wrap_q;
        load_err_d  = load_err_q;
        scratch_d   = scratch_q;
        tick_o      = 1'b0;

        if (wr_en) begin
            case (wr_idx)
                IDX_CTRL: begin
                    if (s_axi.wstrb[0]) begin
                        run_d       = s_axi.wdata[0];
                        load_pend_d = s_axi.wdata[1];
                    end
                end
                IDX_SET: begin
                    if (s_axi.wstrb[0]) set_sec_d  = s_axi.wdata[5:0];
                    if (s_axi.wstrb[1]) set_min_d  = s_axi.wdata[13:8];
                    if (s_axi.wstrb[2]) set_hour_d = s_axi.wdata[20:16];
                end
                IDX_TIME: begin
                end
                IDX_STATUS: begin
                    if (s_axi.wstrb[0] && s_axi.wdata[1]) day_wrap_d = 1'b0;
                    if (s_axi.wstrb[0] && s_axi.wdata[2]) load_err_d = 1'b0;
                end
                default: scratch_d[wr_idx] = merge_bytes(scratch_q[wr_idx], s_axi.wdata, s_axi.wstrb);
            endcase
        end

        // Sticky-bit sets come after the W1C clears above so a same-cycle set wins.
        if (load_pend_q) begin
            if (set_valid) begin
                sec_d   = set_sec_q;
                min_d   = set_min_q;
                hour_d  = set_hour_q;
                presc_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (run_q) begin
            if (presc_q == PRESC_LAST) begin
                tick_o  = 1'b1;
                presc_d = '0;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d = 6'd0;
                        if (hour_q == 5'd23) begin
                            hour_d     = 5'd0;
                            day_wrap_d = 1'b1;
                        end else begin
                            hour_d = hour_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q  <= WR_IDLE;
            rd_state_q  <= RD_IDLE;
            bresp_q     <= '0;
            rresp_q     <= '0;
            rdata_q     <= '0;
            run_q       <= 1'b0;
            load_pend_q <= 1'b0;
            set_sec_q   <= '0;
            set_min_q   <= '0;
            set_hour_q  <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            presc_q     <= '0;
            day_wrap_q  <= 1'b0;
            load_err_q  <= 1'b0;
            for (int i = 0; i < C_NUM_REGS; i++) scratch_q[i] <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            bresp_q     <= bresp_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            run_q       <= run_d;
            load_pend_q <= load_pend_d;
            set_sec_q   <= set_sec_d;
            set_min_q   <= set_min_d;
            set_hour_q  <= set_hour_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            presc_q     <= presc_d;
            day_wrap_q  <= day_wrap_d;
            load_err_q  <= load_err_d;
            scratch_q   <= scratch_d;
        end
    end

    assign s_axi.awready      = aw_hs;
    assign s_axi.wready       = aw_hs;
    assign s_axi.bvalid       = (wr_state_q == WR_RESP);
    assign s_axi.bresp        = bresp_q;
    assign s_axi.arready      = ar_hs;
    assign s_axi.rvalid       = (rd_state_q == RD_DATA);
    assign s_axi.rdata        = rdata_q;
    assign s_axi.rresp        = rresp_q;
    assign s_axi.wr_state_dbg = wr_state_q;
    assign s_axi.rd_state_dbg = rd_state_q;

    assign sec_o  = sec_q;
    assign min_o  = min_q;
    assign hour_o = hour_q;
endmodule

// File: doc/esr_clock_axi_v2.md
ESR_CLOCK_AXI_V2 -- requirements
Module: esr_clock_axi_v2

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; legal values 32 or 64.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, AXI4-Lite byte-address width.
REQ-003 SHALL have parameter C_NUM_REGS, default 8, register count; a power of 2 in the range 4..16, with C_NUM_REGS*(DATA_WIDTH/8) <= 2^ADDR_WIDTH.
REQ-004 SHALL have parameter C_TICK_DIV, default 100000000, ACLK cycles per second tick; legal range >= 2.
REQ-005 SHALL have port ACLK, input, 1, sole clock; all logic on the rising edge.
REQ-006 SHALL have port ARESET, input, 1, asynchronous active-high reset.
REQ-007 SHALL have the AXI4-Lite slave ports S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY, at standard widths derived from the parameters.
REQ-008 SHALL have port sec_o, output, 6, current seconds.
REQ-009 SHALL have port min_o, output, 6, current minutes.
REQ-010 SHALL have port hour_o, output, 5, current hours.
REQ-011 SHALL have port tick_o, output, 1, one-cycle pulse on each seconds increment.

Function
REQ-012 SHALL use this register map (index = addr[ADDR_LSB +: log2 C_NUM_REGS], where ADDR_LSB = log2(DATA_WIDTH/8); sub-word address bits are ignored):
  - 0 CTRL, RW: bit0 run, bit1 load (self-clearing, reads 0).
  - 1 SET, RW: hour[20:16], min[13:8], sec[5:0].
  - 2 TIME, RO: live value in SET format.
  - 3 STATUS: bit0 running, RO; bit1 day_wrap, sticky, W1C; bit2 load_err, sticky, W1C.
  - 4..C_NUM_REGS-1 SCRATCH, RW.
  - Unused bits read 0.
REQ-013 Write channel SHALL assert AWREADY and WREADY together for exactly one cycle, only when AWVALID=1, WVALID=1 and BVALID=0.
REQ-014 BVALID SHALL assert the cycle after the AW/W handshake and hold until BREADY=1; no new write is accepted while BVALID=1.
REQ-015 Writes SHALL honour WSTRB per byte; writes to RO fields SHALL be ignored with BRESP=OKAY.
REQ-016 Write address >= C_NUM_REGS*(DATA_WIDTH/8) SHALL change no state and return BRESP=SLVERR (2'b10).
REQ-017 ARREADY SHALL pulse one cycle when ARVALID=1 and RVALID=0; RVALID/RDATA SHALL follow next cycle and hold stable until RREADY=1.
REQ-018 Out-of-range read SHALL return RDATA=0, RRESP=SLVERR.
REQ-019 With run=1, the prescaler SHALL count 0..C_TICK_DIV-1; at the terminal count it wraps to 0, tick_o pulses, and sec increments.
REQ-020 Rollover: sec 59->0 carries into min; min 59->0 carries into hour; hour 23->0 sets day_wrap.
REQ-021 With run=0, the prescaler and time SHALL hold and tick_o=0.
REQ-022 A CTRL write with bit1=1 SHALL, on the next cycle, copy SET into time and clear the prescaler, provided the SET fields are valid (sec<=59, min<=59, hour<=23); otherwise time is unchanged and load_err sets.
REQ-023 Load and tick in the same cycle: load SHALL win and tick_o SHALL be suppressed.
REQ-024 A hardware set of day_wrap and a W1C of day_wrap in the same cycle: the set SHALL win.
REQ-025 A TIME read SHALL return the value registered at the ARREADY cycle.
REQ-026 Independent read and write channels SHALL operate concurrently.

Reset
REQ-027 While ARESET=1, all READY/VALID outputs SHALL be 0, BRESP/RRESP/RDATA 0, all registers 0, time 00:00:00, prescaler 0, tick_o 0.
REQ-028 ARESET asserted mid-transaction SHALL abort the transaction with no response; the master restarts after release.
REQ-029 The first handshake SHALL be accepted one cycle after ARESET deasserts.

Verification (C_TICK_DIV=4, 32-bit, C_NUM_REGS=8)
REQ-030 Write 0x1,0x2,0x3,0x4 to SCRATCH 0x10..0x1C, then read back -> identical data, OKAY.
REQ-031 SET=0x0017_3B3B, CTRL=0x3 -> TIME=0x00173B3B; 4 cycles later TIME=0x00000000, day_wrap=1, one tick_o pulse; write STATUS 0x2 -> day_wrap=0.
REQ-032 SET=0x0000_3C00, CTRL=0x2 -> load_err=1, TIME unchanged.
REQ-033 Write 0xAABBCCDD, WSTRB=4'b0101 to SCRATCH 0x14 (reset value 0) -> reads 0x00BB00DD.
REQ-034 Write/read at 0x20 -> SLVERR, read data 0, no register changes; BREADY held low 5 cycles -> BVALID held, AWREADY stays 0.
REQ-035 ARESET pulsed while run=1 with time 00:00:05 -> all outputs 0, TIME=0, running=0.
